// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the instruction register / memory and the multicycle
// controller. master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if #(
  parameter int ALU_OP_W = 4
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                mem_ready;
  logic                PCWrite;
  logic                Branch;
  logic                BranchNe;
  logic [1:0]          PCSrc;
  logic [ALU_OP_W-1:0] ALUControl;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic                ExtZero;
  logic                RegWrite;
  logic                RegDst;
  logic                MemToReg;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                illegal;
  logic [3:0]          state_o;

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, Branch, BranchNe, PCSrc, ALUControl, ALUSrcA, ALUSrcB,
           ExtZero, RegWrite, RegDst, MemToReg, IorD, MemRead, MemWrite,
           IRWrite, illegal, state_o
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, Branch, BranchNe, PCSrc, ALUControl, ALUSrcA, ALUSrcB,
           ExtZero, RegWrite, RegDst, MemToReg, IorD, MemRead, MemWrite,
           IRWrite, illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory-ready stalls and illegal-opcode flag.
// Optional perf counters (cycle_cnt, retire_cnt) with MULTICYCLE_CTRL_PERF_EN.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4, wait for mem_ready
// DECODE | register read, branch target precompute, opcode dispatch
// MEMADR | load/store address = A + sext(imm)
// MEMRD  | load data read, wait for mem_ready
// MEMWB  | load data to rt
// MEMWR  | store write, wait for mem_ready
// REXEC  | R-type ALU op from funct
// RWB    | ALUOut to rd
// BRANCH | compare A - B, conditional PC write to branch target
// IEXEC  | I-type ALU op with immediate
// IWB    | ALUOut to rt
// JUMP   | PC = jump target
module multicycle_ctrl_fsm #(
  parameter int ALU_OP_W      = 4,
  parameter bit USE_MEM_READY = 1'b1,
  parameter int PERF_CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]  cycle_cnt,
  output logic [PERF_CNT_W-1:0]  retire_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_NOR = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(9);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t state;
  state_t state_next;
  logic   mem_rdy;

  assign mem_rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = FETCH;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.BranchNe   = 1'b0;
    bus.PCSrc      = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ExtZero    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemToReg   = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.illegal    = 1'b0;
    bus.state_o    = 4'd0;
    // Outputs held at defaults during reset so no write leaks past the edge.
    if (rst_n) begin
      bus.state_o = state;
      case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = mem_rdy;
          bus.PCWrite = mem_rdy;
          state_next  = mem_rdy ? DECODE : FETCH;
        end
        DECODE: begin
          bus.ALUSrcB = 2'b11;
          case (bus.opcode)
            OP_RTYPE:                         state_next = REXEC;
            OP_LW, OP_SW:                     state_next = MEMADR;
            OP_BEQ, OP_BNE:                   state_next = BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = IEXEC;
            OP_J:                             state_next = JUMP;
            default: begin
              state_next  = FETCH;
              bus.illegal = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          state_next  = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
          state_next  = mem_rdy ? MEMWB : MEMRD;
        end
        MEMWB: begin
          bus.MemToReg = 1'b1;
          bus.RegWrite = 1'b1;
        end
        MEMWR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
          state_next   = mem_rdy ? FETCH : MEMWR;
        end
        REXEC: begin
          bus.ALUSrcA = 1'b1;
          state_next  = RWB;
          case (bus.funct)
            FN_AND:  bus.ALUControl = ALU_AND;
            FN_OR:   bus.ALUControl = ALU_OR;
            FN_XOR:  bus.ALUControl = ALU_XOR;
            FN_NOR:  bus.ALUControl = ALU_NOR;
            FN_ADD:  bus.ALUControl = ALU_ADD;
            FN_SUB:  bus.ALUControl = ALU_SUB;
            FN_SLT:  bus.ALUControl = ALU_SLT;
            FN_SLL:  bus.ALUControl = ALU_SLL;
            FN_SRL:  bus.ALUControl = ALU_SRL;
            FN_SRA:  bus.ALUControl = ALU_SRA;
            default: bus.ALUControl = ALU_ADD;
          endcase
        end
        RWB: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA    = 1'b1;
          bus.ALUControl = ALU_SUB;
          bus.PCSrc      = 2'b01;
          bus.Branch     = (bus.opcode == OP_BEQ);
          bus.BranchNe   = (bus.opcode == OP_BNE);
        end
        IEXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          state_next  = IWB;
          case (bus.opcode)
            OP_ANDI: begin
              bus.ALUControl = ALU_AND;
              bus.ExtZero    = 1'b1;
            end
            OP_ORI: begin
              bus.ALUControl = ALU_OR;
              bus.ExtZero    = 1'b1;
            end
            OP_SLTI: bus.ALUControl = ALU_SLT;
            default: bus.ALUControl = ALU_ADD;
          endcase
        end
        IWB: bus.RegWrite = 1'b1;
        JUMP: begin
          bus.PCSrc   = 2'b10;
          bus.PCWrite = 1'b1;
        end
        default: state_next = FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  // Retire = return to FETCH after real work; illegal DECODE exits don't count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + PERF_CNT_W'(1);
      if (state_next == FETCH && state != FETCH && state != DECODE)
        retire_cnt <= retire_cnt + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm against an instruction-level model.
// Define MULTICYCLE_CTRL_PERF_EN to also check the perf counters.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.ALU_OP_W(4)) bus();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  multicycle_ctrl_fsm #(.ALU_OP_W(4), .USE_MEM_READY(1'b1), .PERF_CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
`endif
  );

  localparam logic [3:0] A_AND = 4'd0, A_OR  = 4'd1, A_ADD = 4'd2, A_XOR = 4'd3,
                         A_NOR = 4'd4, A_SLL = 4'd5, A_SUB = 4'd6, A_SLT = 4'd7,
                         A_SRL = 4'd8, A_SRA = 4'd9;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic       pcw, br, brne;
    logic [1:0] pcsrc;
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       extz, rw, rdst, m2r, iord, mrd, mwr, irw, ill;
  } cyc_t;

  int checks = 0;
  int errors = 0;
  int cyc_model = 0;
  int ret_model = 0;
  cyc_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cyc_t dflt(input logic [3:0] st, input logic mr);
    cyc_t c;
    c.st = st; c.mr = mr; c.pcw = 0; c.br = 0; c.brne = 0; c.pcsrc = 0;
    c.alu = A_ADD; c.srca = 0; c.srcb = 0; c.extz = 0; c.rw = 0; c.rdst = 0;
    c.m2r = 0; c.iord = 0; c.mrd = 0; c.mwr = 0; c.irw = 0; c.ill = 0;
    return c;
  endfunction

  function automatic logic [31:0] pack(input cyc_t c);
    return {7'd0, c.st, c.pcw, c.br, c.brne, c.pcsrc, c.alu, c.srca, c.srcb,
            c.extz, c.rw, c.rdst, c.m2r, c.iord, c.mrd, c.mwr, c.irw, c.ill};
  endfunction

  function automatic logic [31:0] obs();
    return {7'd0, bus.state_o, bus.PCWrite, bus.Branch, bus.BranchNe, bus.PCSrc,
            bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ExtZero, bus.RegWrite,
            bus.RegDst, bus.MemToReg, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.illegal};
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'h24: return A_AND;  6'h25: return A_OR;   6'h26: return A_XOR;
      6'h27: return A_NOR;  6'h22: return A_SUB;  6'h2A: return A_SLT;
      6'h00: return A_SLL;  6'h02: return A_SRL;  6'h03: return A_SRA;
      default: return A_ADD;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  endfunction

  // Expected per-cycle outputs for one instruction, starting at FETCH.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    cyc_t c;
    logic [3:0] mst;
    exp_q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = dflt(4'd0, (i == fw));
      c.mrd = 1; c.srcb = 2'b01; c.irw = (i == fw); c.pcw = (i == fw);
      exp_q.push_back(c);
    end
    c = dflt(4'd1, 1'($urandom)); c.srcb = 2'b11; c.ill = !is_legal(op);
    exp_q.push_back(c);
    if (op == 6'h00) begin
      c = dflt(4'd6, 1'($urandom)); c.srca = 1; c.alu = rtype_alu(fn); exp_q.push_back(c);
      c = dflt(4'd7, 1'($urandom)); c.rdst = 1; c.rw = 1; exp_q.push_back(c);
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = dflt(4'd2, 1'($urandom)); c.srca = 1; c.srcb = 2'b10; exp_q.push_back(c);
      mst = (op == 6'h23) ? 4'd3 : 4'd5;
      for (int i = 0; i <= mw; i++) begin
        c = dflt(mst, (i == mw)); c.iord = 1;
        if (op == 6'h23) c.mrd = 1; else c.mwr = 1;
        exp_q.push_back(c);
      end
      if (op == 6'h23) begin
        c = dflt(4'd4, 1'($urandom)); c.m2r = 1; c.rw = 1; exp_q.push_back(c);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = dflt(4'd8, 1'($urandom)); c.srca = 1; c.alu = A_SUB; c.pcsrc = 2'b01;
      c.br = (op == 6'h04); c.brne = (op == 6'h05); exp_q.push_back(c);
    end else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D}) begin
      c = dflt(4'd9, 1'($urandom)); c.srca = 1; c.srcb = 2'b10;
      c.alu  = (op == 6'h0C) ? A_AND : (op == 6'h0D) ? A_OR : (op == 6'h0A) ? A_SLT : A_ADD;
      c.extz = (op == 6'h0C || op == 6'h0D);
      exp_q.push_back(c);
      c = dflt(4'd10, 1'($urandom)); c.rw = 1; exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = dflt(4'd11, 1'($urandom)); c.pcsrc = 2'b10; c.pcw = 1; exp_q.push_back(c);
    end
  endtask

  task automatic step(input cyc_t c);
    bus.mem_ready = c.mr;
    #1;
    chk($sformatf("st%0d", c.st), obs(), pack(c));
    @(negedge clk);
    cyc_model++;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    int base;
    bus.opcode = op;
    bus.funct  = fn;
    build(op, fn, fw, mw);
    base = cyc_model;
    foreach (exp_q[i]) step(exp_q[i]);
    if (is_legal(op)) ret_model++;
    // Instruction length with mem_ready high: R 4, I 4, LW 5, SW 4, br 3, J 3.
    case (op)
      6'h23:                       chk("len_lw", cyc_model - base, 5 + fw + mw);
      6'h2B:                       chk("len_sw", cyc_model - base, 4 + fw + mw);
      6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D: chk("len_alu", cyc_model - base, 4 + fw);
      6'h02, 6'h04, 6'h05:         chk("len_br", cyc_model - base, 3 + fw);
      default:                     chk("len_ill", cyc_model - base, 2 + fw);
    endcase
  endtask

  logic [5:0] ops [12];
  logic [5:0] bad_ops [5];
  logic [5:0] fns [11];

  initial begin
    cyc_t c;
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F};
    bad_ops = '{6'h3F, 6'h01, 6'h03, 6'h20, 6'h10};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h21};

    rst_n = 1'b0;
    bus.opcode = 6'h2B; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_out", obs(), pack(dflt(4'd0, 1'b0)));
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("reset_cyc", cycle_cnt, 32'd0);
    chk("reset_ret", retire_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'h00, 6'h20, 0, 0);
    run_instr(6'h23, 6'h00, 0, 3);
    run_instr(6'h2B, 6'h00, 2, 2);
    run_instr(6'h05, 6'h00, 0, 0);
    run_instr(6'h04, 6'h00, 1, 0);
    run_instr(6'h02, 6'h00, 0, 0);
    run_instr(6'h3F, 6'h00, 0, 0);
    run_instr(6'h0D, 6'h00, 0, 0);

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 11)];
      if (op == 6'h3F) op = bad_ops[$urandom_range(0, 4)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 10)];
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 4));
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("cycle_cnt", cycle_cnt, cyc_model);
    chk("retire_cnt", retire_cnt, ret_model);
`endif

    // Reset while a store is waiting on memory.
    bus.opcode = 6'h2B;
    build(6'h2B, 6'h00, 0, 5);
    for (int i = 0; i < 4; i++) step(exp_q[i]);
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_mid_out", obs(), pack(dflt(4'd0, 1'b0)));
    chk("rst_mid_mwr", {31'd0, bus.MemWrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    c = dflt(4'd0, 1'b0); c.mrd = 1; c.srcb = 2'b01;
    #1;
    chk("rst_after", obs(), pack(c));
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("rst_after_cyc", cycle_cnt, 32'd0);
    chk("rst_after_ret", retire_cnt, 32'd0);
`endif
    @(negedge clk);
    cyc_model = 1;
    ret_model = 0;
    run_instr(6'h02, 6'h00, 0, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("final_cyc", cycle_cnt, cyc_model);
    chk("final_ret", retire_cnt, ret_model);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Next-generation multicycle MIPS control unit. Drives the datapath mux selects and write enables from opcode/funct.
- Adds I-type, load/store, branch and jump flows.
- Adds a memory-ready handshake so memory accesses stall for variable latency, a synchronous reset and an illegal-opcode flag.
- Sits between the instruction register and the datapath in the CPU top level. Opcode, funct and ALU encodings come from cpu.svh.

Parameters:
- ALU_OP_W, 4, width of ALUControl; must match the `ALU_* encodings.
- USE_MEM_READY, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- PERF_CNT_W, 32, counter width for the optional feature.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  instruction[31:26] from the IR.
- funct  in  6  instruction[5:0] from the IR.
- mem_ready  in  1  memory completed the current access this cycle.
- PCWrite  out  1  unconditional PC write.
- Branch  out  1  PC write if ALU zero (beq).
- BranchNe  out  1  PC write if ALU not zero (bne).
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUControl  out  ALU_OP_W  ALU operation.
- ALUSrcA  out  1  0 PC, 1 register A.
- ALUSrcB  out  2  00 B, 01 constant 4, 10 extended immediate, 11 sign-extended immediate << 2.
- ExtZero  out  1  1 = zero-extend the immediate (andi/ori), 0 = sign-extend.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  1 rd, 0 rt.
- MemToReg  out  1  1 memory data, 0 ALUOut.
- IorD  out  1  0 PC address, 1 ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Output defaults: every output is 0, ALUControl = `ALU_ADD. Outputs are combinational from the state register (plus mem_ready and funct where stated). While rst_n = 0 all outputs equal these defaults.
- Reset: rst_n = 0 at a posedge sets state to FETCH. This applies mid-operation too; no pending write completes after the reset edge.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 REXEC, 7 RWB.
  - 8 BRANCH, 9 IEXEC, 10 IWB, 11 JUMP.
- FETCH:
  - IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ADD, PCSrc = 00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ADD. Next state by opcode:
  - RTYPE (00) → REXEC.
  - LW (23), SW (2B) → MEMADR.
  - BEQ (04), BNE (05) → BRANCH.
  - ADDI (08), ANDI (0C), ORI (0D), SLTI (0A) → IEXEC.
  - J (02) → JUMP.
  - Any other opcode → FETCH, with illegal = 1 for this cycle.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ADD. Next MEMRD if LW, MEMWR if SW.
- MEMRD:
  - IorD = 1, MemRead = 1.
  - Holds until mem_ready, then → MEMWB.
- MEMWB: RegDst = 0, MemToReg = 1, RegWrite = 1. Next FETCH.
- MEMWR:
  - IorD = 1, MemWrite = 1.
  - Holds until mem_ready, then → FETCH.
  - MemWrite stays high for the whole wait.
- REXEC:
  - ALUSrcA = 1, ALUSrcB = 00.
  - ALUControl from funct: AND, OR, XOR, NOR, ADD, SUB, SLT, SLL, SRL, SRA. Unknown funct → ADD.
  - Next RWB.
- RWB: RegDst = 1, MemToReg = 0, RegWrite = 1. Next FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, SUB, PCSrc = 01.
  - Branch = 1 for BEQ; BranchNe = 1 for BNE.
  - Next FETCH.
- IEXEC:
  - ALUSrcA = 1, ALUSrcB = 10.
  - ADDI → ADD, ANDI → AND with ExtZero = 1, ORI → OR with ExtZero = 1, SLTI → SLT.
  - Next IWB.
- IWB: RegDst = 0, MemToReg = 0, RegWrite = 1. Next FETCH.
  - ExtZero in IWB: 0. The extended immediate is consumed in IEXEC only.
- JUMP: PCSrc = 10, PCWrite = 1. Next FETCH.
- Undefined state encoding → FETCH on the next edge, outputs at defaults.
- Opcode and funct must be stable from DECODE to writeback; the IR guarantees this because IRWrite = 0 outside FETCH.
- USE_MEM_READY = 0: every memory state lasts exactly one cycle.
- Cycle counts with mem_ready tied high:
  - R-type 4, I-type ALU 4, LW 5, SW 4, branch 3, J 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Enabled: adds outputs cycle_cnt and retire_cnt, each PERF_CNT_W bits.
  - cycle_cnt increments every cycle with rst_n = 1.
  - retire_cnt increments on each transition into FETCH from any state other than FETCH and DECODE.
  - Both clear on reset and wrap modulo 2^PERF_CNT_W.
- Disabled: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- R-type path: reset 2 cycles, opcode = 00, funct = 20 (add), mem_ready = 1 → state_o sequence 0,1,6,7,0. ALUControl = `ALU_ADD in REXEC. RegWrite = RegDst = 1 only in RWB.
- LW with wait: opcode = 23, mem_ready low for 3 cycles in MEMRD → state_o 0,1,2,3,3,3,3,4,0. MemToReg = 1 and RegWrite = 1 in MEMWB only.
- SW and fetch stall: mem_ready = 0 for 2 cycles in FETCH → IRWrite/PCWrite = 0 while waiting, 1 in the ready cycle. Opcode = 2B → MemWrite held high through MEMWR until mem_ready.
- Branch/jump: opcode = 05 → BranchNe = 1, Branch = 0, ALUControl = `ALU_SUB, PCSrc = 01. Opcode = 02 → PCWrite = 1, PCSrc = 10, total 3 cycles.
- Illegal and ORI: opcode = 3F → illegal pulses 1 cycle in DECODE, next state 0. Opcode = 0D → ExtZero = 1, ALUControl = `ALU_OR in IEXEC.
- Reset mid-op: rst_n = 0 while in MEMWR with mem_ready = 0 → next state_o = 0, MemWrite = 0. With MULTICYCLE_CTRL_PERF_EN, the counters read 0 after reset.
